hazard_stall_unit: RTL and testbench

//  Stall/flush controller for the 5-stage LEGv8 pipeline; the counterpart of the
//  EX-stage forwarding logic. It covers the hazards bypassing cannot:
//  - load-use: inserts one bubble.
//  - taken branch resolved in ID: flushes the fetched slot.
//  - multi-cycle data memory: freezes the whole pipeline, with timeout error.
//  It also keeps a saturating stall-cycle counter.

---
 rtl/hazard_stall_unit_if.sv | 35 +++
 rtl/hazard_stall_unit.sv | 108 ++++++++++
 tb/tb_hazard_stall_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Pipeline hazard bundle between the ID/EX control path and the stall/flush controller.
// The pipeline side drives the hazard inputs; the controller drives the stall, flush and hold controls.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IFID_Rn;
  logic [4:0]       IFID_Rm;
  logic             IFID_UsesRn;
  logic             IFID_UsesRm;
  logic [4:0]       IDEX_Rd;
  logic             IDEX_MemRead;
  logic             branch_taken;
  logic             mem_busy;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXBubble;
  logic             IFIDFlush;
  logic             PipeHold;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output IFID_Rn, IFID_Rm, IFID_UsesRn, IFID_UsesRm, IDEX_Rd, IDEX_MemRead,
           branch_taken, mem_busy,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeHold, mem_timeout,
           stall_cycles
  );

  modport slave (
    input  IFID_Rn, IFID_Rm, IFID_UsesRn, IFID_UsesRm, IDEX_Rd, IDEX_MemRead,
           branch_taken, mem_busy,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeHold, mem_timeout,
           stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage LEGv8 pipeline: load-use bubbles, ID-resolved
// branch flushes, and whole-pipe freezes while data memory is busy, with a timeout trap.
module hazard_stall_unit #(
  parameter int ZERO_REG   = 31,
  parameter int DELAY_SLOT = 0,
  parameter int WAIT_MAX   = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_stall_unit_if.slave hs
);
  localparam int WC = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WC-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic lu;
  logic pc_write, ifid_write, idex_bubble, ifid_flush, pipe_hold, timeout;

  assign lu = hs.IDEX_MemRead && (hs.IDEX_Rd != 5'(ZERO_REG)) &&
              ((hs.IFID_UsesRn && (hs.IFID_Rn == hs.IDEX_Rd)) ||
               (hs.IFID_UsesRm && (hs.IFID_Rm == hs.IDEX_Rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_hold   = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      RUN, MEM_WAIT: begin
        if (hs.mem_busy) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          if (state_q == RUN) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WC'(1);
          end else if (wait_cnt_q == WC'(WAIT_MAX)) begin
            state_d = ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          // Memory done: the ordinary hazard rules apply in this very cycle.
          state_d    = RUN;
          wait_cnt_d = '0;
          if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (hs.branch_taken && (DELAY_SLOT == 0)) begin
            ifid_flush = 1'b1;
          end
        end
      end
      ERROR: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_hold  = 1'b1;
        timeout    = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  assign hs.PCWrite      = pc_write;
  assign hs.IFIDWrite    = ifid_write;
  assign hs.IDEXBubble   = idex_bubble;
  assign hs.IFIDFlush    = ifid_flush;
  assign hs.PipeHold     = pipe_hold;
  assign hs.mem_timeout  = timeout;
  assign hs.stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a default instance plus a delay-slot instance
// with a 2-bit stall counter, both fed the same pipeline stimulus.
module tb_hazard_stall_unit;
  logic clk;
  logic reset;

  logic [4:0] rn, rm, rd;
  logic       uses_rn, uses_rm, memread, branch, busy;

  int n_cmp;
  int n_bad;

  hazard_stall_unit_if #(.CNT_W(16)) if0 ();
  hazard_stall_unit_if #(.CNT_W(2))  if1 ();

  assign if0.IFID_Rn = rn;      assign if1.IFID_Rn = rn;
  assign if0.IFID_Rm = rm;      assign if1.IFID_Rm = rm;
  assign if0.IFID_UsesRn = uses_rn;  assign if1.IFID_UsesRn = uses_rn;
  assign if0.IFID_UsesRm = uses_rm;  assign if1.IFID_UsesRm = uses_rm;
  assign if0.IDEX_Rd = rd;      assign if1.IDEX_Rd = rd;
  assign if0.IDEX_MemRead = memread; assign if1.IDEX_MemRead = memread;
  assign if0.branch_taken = branch;  assign if1.branch_taken = branch;
  assign if0.mem_busy = busy;   assign if1.mem_busy = busy;

  // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeHold, mem_timeout}
  wire [5:0] o0 = {if0.PCWrite, if0.IFIDWrite, if0.IDEXBubble, if0.IFIDFlush,
                   if0.PipeHold, if0.mem_timeout};
  wire [5:0] o1 = {if1.PCWrite, if1.IFIDWrite, if1.IDEXBubble, if1.IFIDFlush,
                   if1.PipeHold, if1.mem_timeout};

  hazard_stall_unit #(.ZERO_REG(31), .DELAY_SLOT(0), .WAIT_MAX(15), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .hs(if0.slave)
  );
  hazard_stall_unit #(.ZERO_REG(31), .DELAY_SLOT(1), .WAIT_MAX(15), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .hs(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rn = 5'd0; rm = 5'd0; rd = 5'd0;
    uses_rn = 1'b0; uses_rm = 1'b0; memread = 1'b0; branch = 1'b0; busy = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (o0 !== 6'b110000) begin n_bad++; $display("FAIL reset_out0: got %b want 110000", o0); end
    n_cmp++; if (o1 !== 6'b110000) begin n_bad++; $display("FAIL reset_out1: got %b want 110000", o1); end
    n_cmp++; if (if0.stall_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_stall0: got %0d want 0", if0.stall_cycles); end
    $display("reset: out0=%b stall0=%0d", o0, if0.stall_cycles);
  endtask

  task automatic test_load_use();
    // LDUR X2 in EX, ADD X3,X2,X4 in ID
    @(negedge clk); memread = 1'b1; rd = 5'd2; rn = 5'd2; uses_rn = 1'b1; rm = 5'd4; uses_rm = 1'b1; #1;
    n_cmp++; if (o0 !== 6'b001000) begin n_bad++; $display("FAIL lu_rn_out: got %b want 001000", o0); end
    n_cmp++; if (if0.stall_cycles !== 16'd0) begin n_bad++; $display("FAIL lu_rn_stall_pre: got %0d want 0", if0.stall_cycles); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (o0 !== 6'b110000) begin n_bad++; $display("FAIL lu_one_cycle: got %b want 110000", o0); end
    n_cmp++; if (if0.stall_cycles !== 16'd1) begin n_bad++; $display("FAIL lu_rn_stall: got %0d want 1", if0.stall_cycles); end
    $display("load_use Rn: stall0=%0d", if0.stall_cycles);
    @(negedge clk); memread = 1'b1; rd = 5'd9; rn = 5'd7; uses_rn = 1'b1; rm = 5'd9; uses_rm = 1'b1; #1;
    n_cmp++; if (o0 !== 6'b001000) begin n_bad++; $display("FAIL lu_rm_out: got %b want 001000", o0); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (if0.stall_cycles !== 16'd2) begin n_bad++; $display("FAIL lu_rm_stall: got %0d want 2", if0.stall_cycles); end
    $display("load_use Rm: stall0=%0d", if0.stall_cycles);
  endtask

  task automatic test_zero_reg();
    @(negedge clk); memread = 1'b1; rd = 5'd31; rn = 5'd31; uses_rn = 1'b1; #1;
    n_cmp++; if (o0 !== 6'b110000) begin n_bad++; $display("FAIL zr_xzr: got %b want 110000", o0); end
    rd = 5'd5; rn = 5'd1; rm = 5'd5; uses_rm = 1'b0; #1;
    n_cmp++; if (o0 !== 6'b110000) begin n_bad++; $display("FAIL zr_unused_rm: got %b want 110000", o0); end
    memread = 1'b0; rn = 5'd5; uses_rm = 1'b1; #1;
    n_cmp++; if (o0 !== 6'b110000) begin n_bad++; $display("FAIL zr_no_load: got %b want 110000", o0); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (if0.stall_cycles !== 16'd2) begin n_bad++; $display("FAIL zr_stall: got %0d want 2", if0.stall_cycles); end
    $display("zero_reg: stall0=%0d", if0.stall_cycles);
  endtask

  task automatic test_branch();
    @(negedge clk); branch = 1'b1; #1;
    n_cmp++; if (o0 !== 6'b110100) begin n_bad++; $display("FAIL br_flush: got %b want 110100", o0); end
    n_cmp++; if (o1 !== 6'b110000) begin n_bad++; $display("FAIL br_delay_slot: got %b want 110000", o1); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (o0 !== 6'b110000) begin n_bad++; $display("FAIL br_one_cycle: got %b want 110000", o0); end
    $display("branch: out0=%b out1=%b", o0, o1);
  endtask

  task automatic test_lu_branch();
    @(negedge clk); memread = 1'b1; rd = 5'd2; rn = 5'd2; uses_rn = 1'b1; branch = 1'b1; #1;
    n_cmp++; if (o0 !== 6'b001000) begin n_bad++; $display("FAIL lubr_out0: got %b want 001000", o0); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (if0.stall_cycles !== 16'd3) begin n_bad++; $display("FAIL lubr_stall0: got %0d want 3", if0.stall_cycles); end
    n_cmp++; if (if1.stall_cycles !== 2'd3) begin n_bad++; $display("FAIL lubr_stall1: got %0d want 3", if1.stall_cycles); end
    $display("lu+branch: stall0=%0d stall1=%0d", if0.stall_cycles, if1.stall_cycles);
  endtask

  task automatic test_mem_busy();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); busy = 1'b1; branch = 1'b1; memread = 1'b1; rd = 5'd2; rn = 5'd2; uses_rn = 1'b1; #1;
      n_cmp++; if (o0 !== 6'b000010) begin n_bad++; $display("FAIL busy_hold[%0d]: got %b want 000010", i, o0); end
    end
    @(negedge clk); idle(); branch = 1'b1; #1;
    n_cmp++; if (o0 !== 6'b110100) begin n_bad++; $display("FAIL busy_release: got %b want 110100", o0); end
    n_cmp++; if (if0.stall_cycles !== 16'd6) begin n_bad++; $display("FAIL busy_stall0: got %0d want 6", if0.stall_cycles); end
    n_cmp++; if (if1.stall_cycles !== 2'd3) begin n_bad++; $display("FAIL busy_sat1: got %0d want 3", if1.stall_cycles); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (o0 !== 6'b110000) begin n_bad++; $display("FAIL busy_run: got %b want 110000", o0); end
    $display("mem_busy 3: stall0=%0d stall1=%0d", if0.stall_cycles, if1.stall_cycles);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); busy = 1'b1; #1;
      if (i == 9) begin
        n_cmp++; if (o0 !== 6'b000010) begin n_bad++; $display("FAIL to_wait: got %b want 000010", o0); end
      end
      if (i == 19) begin
        n_cmp++; if (o0 !== 6'b000011) begin n_bad++; $display("FAIL to_error: got %b want 000011", o0); end
      end
    end
    @(negedge clk); idle(); #1;
    n_cmp++; if (o0 !== 6'b000011) begin n_bad++; $display("FAIL to_sticky: got %b want 000011", o0); end
    n_cmp++; if (if0.stall_cycles !== 16'd26) begin n_bad++; $display("FAIL to_stall: got %0d want 26", if0.stall_cycles); end
    @(negedge clk); #1;
    n_cmp++; if (o0 !== 6'b000011) begin n_bad++; $display("FAIL to_sticky2: got %b want 000011", o0); end
    $display("timeout: out0=%b stall0=%0d", o0, if0.stall_cycles);
    #2 reset = 1'b0; #1;
    n_cmp++; if (o0 !== 6'b110000) begin n_bad++; $display("FAIL to_reset_out0: got %b want 110000", o0); end
    n_cmp++; if (if0.stall_cycles !== 16'd0) begin n_bad++; $display("FAIL to_reset_stall0: got %0d want 0", if0.stall_cycles); end
    n_cmp++; if (if1.stall_cycles !== 2'd0) begin n_bad++; $display("FAIL to_reset_stall1: got %0d want 0", if1.stall_cycles); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); branch = 1'b1; #1;
    n_cmp++; if (o0 !== 6'b110100) begin n_bad++; $display("FAIL to_after_reset: got %b want 110100", o0); end
    @(negedge clk); idle();
    $display("reset mid-error: out0=%b stall0=%0d", o0, if0.stall_cycles);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    idle();
    #3;
    test_reset();
    @(negedge clk); reset = 1'b1;
    test_load_use();
    test_zero_reg();
    test_branch();
    test_lu_branch();
    test_mem_busy();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
